bp_be_stride_pf_issuer: RTL
===========================

# bp_be_stride_pf_issuer

Downstream consumer of the backend reference-prediction-table stride-detection stream. Tracks one load stream from discovery start to confirmation. On confirmation, issues up to `pf_degree_p` cache-line prefetch requests at `base + k*stride` over a valid/ready port to the D$ prefetch queue. Sits in bp_be_checker between the RPT and the D$ prefetch port.

## Interface
- `vaddr_width_p`, from bp_params: virtual address width.
- `stride_width_p`, 8: stride width, two's complement signed.
- `pf_degree_p`, 4: maximum prefetch candidates per confirmed stream; must be ≥1.
- `line_offset_width_p`, 6: log2 of the cache line size in bytes.
- `page_offset_width_p`, 12: log2 of the page size.
- `timeout_p`, 64: idle cycles allowed in discovery before the stream is abandoned.
- Reset: one clock; reset is asynchronous and active-low.
- `clk_i` in 1: clock.
- `reset_n_i` in 1: asynchronous active-low reset.
- `flush_i` in 1: synchronous abort to idle.
- `stride_v_i` in 1: stride report valid; single-cycle pulse.
- `stride_i` in stride_width_p: reported stride.
- `pc_i` in vaddr_width_p: PC of the reporting load.
- `eff_addr_i` in vaddr_width_p: effective address of the reporting load.
- `start_discovery_i` in 1: qualifier; only meaningful with `stride_v_i`.
- `confirm_discovery_i` in 1: qualifier; only meaningful with `stride_v_i`.
- `pf_v_o` out 1: prefetch request valid.
- `pf_vaddr_o` out vaddr_width_p: line-aligned prefetch address; low `line_offset_width_p` bits are zero.
- `pf_ready_i` in 1: prefetch queue ready.
- `busy_o` out 1: state ≠ e_idle.

## Operation
- **States:** e_idle, e_discover, e_issue.
- **e_idle:**
  - `stride_v_i & start_discovery_i` captures `pc_r`, clears `tmo_cnt`, and moves to e_discover.
  - All other input is ignored.
- **e_discover:**
  - `stride_v_i` clears `tmo_cnt`; otherwise `tmo_cnt` increments.
  - `tmo_cnt == timeout_p-1` without a report returns to e_idle.
  - `stride_v_i & start_discovery_i` re-captures `pc_r` and stays in e_discover.
  - `stride_v_i & confirm_discovery_i & stride_i != 0`:
    - Capture `base_r = eff_addr_i` and `stride_r = stride_i`.
    - Clear `k = 0` and `last_line_r = eff_addr_i >> line_offset_width_p`.
    - Move to e_issue.
  - Confirm with `stride_i == 0` returns to e_idle and issues nothing.
  - Start and confirm asserted together: confirm wins.
- **e_issue:** candidate address `cand = base_r + sext(stride_r)*(k+1)`, computed modulo 2^vaddr_width_p.
  - **Page cross:** if `cand[vaddr-1:page_offset_width_p] != base_r[vaddr-1:page_offset_width_p]`, return to e_idle with no request.
  - **Same line:** if `cand >> line_offset_width_p == last_line_r`, skip it. `k` increments, `pf_v_o` stays low for that cycle, and the skip counts toward the degree.
  - **Otherwise:**
    - Drive `pf_v_o = 1` and `pf_vaddr_o = {cand[vaddr-1:line_offset_width_p], 0}`.
    - Hold both stable until `pf_ready_i`.
    - On the handshake, update `last_line_r` and increment `k`.
  - After candidate `k == pf_degree_p-1` is handshaken or skipped, return to e_idle.
  - New stride reports arriving in e_issue are dropped.
- **flush_i:** has priority over everything, in any state. It moves to e_idle and drops `pf_v_o` in the same edge, even mid-handshake.
- **Reset values:** state e_idle; `pf_v_o = 0`, `pf_vaddr_o = 0`, `busy_o = 0`; all counters and capture registers 0.

## Timing
- All outputs are registered.
- **First request:** a confirm sampled at edge N puts the FSM in e_issue after N. `pf_v_o` rises at edge N+1 and is visible in cycle N+1.
- **Back-to-back:** with `pf_ready_i` held high, one request per cycle. Each skip inserts exactly one bubble.
- **Stall:** while `pf_v_o & ~pf_ready_i`, `pf_vaddr_o`, `k` and the state all hold.
- **Timeout:** exactly `timeout_p` report-free cycles in e_discover leave the state at the next edge.
- **Reset:** assertion takes effect immediately, without waiting for a clock edge. Deassertion is synchronized externally; the block is functional from the first edge after release.

## Test plan
- **Basic stream:**
  - Stimulus: start at pc 0x100; confirm with `eff_addr_i = 0x8000_1000`, `stride_i = 0x40`, `pf_ready_i = 1`.
  - Required: four consecutive requests 0x8000_1040, 0x80, 0xC0, 0x100 beginning 2 cycles after confirm; then `busy_o = 0`.
- **Small stride:**
  - Stimulus: confirm with `stride_i = 0x10`, base 0x2000.
  - Required: a single request 0x2040 after three skip bubbles (candidates 0x2010, 0x2020, 0x2030).
- **Negative stride and page cross:**
  - Stimulus: confirm with `stride_i = 0xC0` (−64), base 0x3040.
  - Required: request 0x3000, then stop at candidate 0x2FC0 (page change); 1 request total.
- **Backpressure:**
  - Stimulus: `pf_ready_i` low for 5 cycles on the first request.
  - Required: `pf_vaddr_o` stable for all 5 cycles; no duplicates; the sequence then resumes.
- **Timeout and zero stride:**
  - Stimulus (a): start, then 64 idle cycles. Required: return to idle.
  - Stimulus (b): confirm with stride 0. Required: return to idle with zero requests.
- **Flush and reset mid-issue:**
  - Stimulus (a): `flush_i` during a stalled request. Required: `pf_v_o` low at the next edge.
  - Stimulus (b): `reset_n_i` low between edges. Required: outputs clear immediately.

Source files
------------

// File: rtl/bp_be_stride_pf_issuer.sv
// Follows one RPT-detected load stream from discovery to confirmation, then issues up to
// pf_degree_p line-aligned prefetches at base + k*stride over a valid/ready port.
module bp_be_stride_pf_issuer
  #(parameter int vaddr_width_p       = 39
   ,parameter int stride_width_p      = 8
   ,parameter int pf_degree_p         = 4
   ,parameter int line_offset_width_p = 6
   ,parameter int page_offset_width_p = 12
   ,parameter int timeout_p           = 64
   )
   (input  logic                      clk_i
   ,input  logic                      reset_n_i
   ,input  logic                      flush_i
   ,input  logic                      stride_v_i
   ,input  logic [stride_width_p-1:0] stride_i
   ,input  logic [vaddr_width_p-1:0]  pc_i
   ,input  logic [vaddr_width_p-1:0]  eff_addr_i
   ,input  logic                      start_discovery_i
   ,input  logic                      confirm_discovery_i
   ,output logic                      pf_v_o
   ,output logic [vaddr_width_p-1:0]  pf_vaddr_o
   ,input  logic                      pf_ready_i
   ,output logic                      busy_o
   );

   localparam int KW = $clog2(pf_degree_p + 1);
   localparam int TW = (timeout_p > 1) ? $clog2(timeout_p) : 1;
   localparam int VW = vaddr_width_p;
   localparam int LO = line_offset_width_p;
   localparam int PO = page_offset_width_p;
   localparam logic [VW-1:0] LINE_MASK = ~VW'((1 << LO) - 1);

   typedef enum logic [1:0] {
      e_idle     = 2'd0,
      e_discover = 2'd1,
      e_issue    = 2'd2
   } state_e;

   state_e                    r_state,    w_stateNxt;
   logic [VW-1:0]             r_pc,       w_pcNxt;
   logic [TW-1:0]             r_tmoCnt,   w_tmoNxt;
   logic [VW-1:0]             r_base,     w_baseNxt;
   logic [stride_width_p-1:0] r_stride,   w_strideNxt;
   logic [KW-1:0]             r_k,        w_kNxt;
   logic [VW-LO-1:0]          r_lastLine, w_lastLineNxt;
   logic                      r_pfV,      w_pfVNxt;
   logic [VW-1:0]             r_pfVaddr,  w_pfVaddrNxt;

   logic                      w_handshake;
   logic [KW-1:0]             w_kEval;
   logic [VW-1:0]             w_kPlus1;
   logic [VW-1:0]             w_strideExt;
   logic [VW-1:0]             w_cand;
   logic [VW-1:0]             w_candAligned;
   logic [VW-LO-1:0]          w_lastEval;
   logic                      w_pageCross;
   logic                      w_sameLine;

   // A handshake this cycle retires candidate k, so the next candidate is evaluated
   // in the same edge to sustain one request per cycle.
   assign w_handshake   = r_pfV & pf_ready_i;
   assign w_kEval       = w_handshake ? (r_k + KW'(1)) : r_k;
   assign w_lastEval    = w_handshake ? r_pfVaddr[VW-1:LO] : r_lastLine;
   assign w_kPlus1      = VW'(w_kEval) + VW'(1);
   assign w_strideExt   = {{(VW-stride_width_p){r_stride[stride_width_p-1]}}, r_stride};
   assign w_cand        = r_base + w_strideExt * w_kPlus1;
   assign w_candAligned = w_cand & LINE_MASK;
   assign w_pageCross   = w_cand[VW-1:PO] != r_base[VW-1:PO];
   assign w_sameLine    = w_candAligned[VW-1:LO] == w_lastEval;

   always_comb begin
      w_stateNxt    = r_state;
      w_pcNxt       = r_pc;
      w_tmoNxt      = r_tmoCnt;
      w_baseNxt     = r_base;
      w_strideNxt   = r_stride;
      w_kNxt        = r_k;
      w_lastLineNxt = r_lastLine;
      w_pfVNxt      = r_pfV;
      w_pfVaddrNxt  = r_pfVaddr;

      case (r_state)
         e_idle: begin
            w_pfVNxt = 1'b0;
            if (stride_v_i & start_discovery_i) begin
               w_pcNxt    = pc_i;
               w_tmoNxt   = '0;
               w_stateNxt = e_discover;
            end
         end
         e_discover: begin
            if (stride_v_i) begin
               w_tmoNxt = '0;
               if (confirm_discovery_i) begin
                  if (stride_i != '0) begin
                     w_baseNxt     = eff_addr_i;
                     w_strideNxt   = stride_i;
                     w_kNxt        = '0;
                     w_lastLineNxt = eff_addr_i[VW-1:LO];
                     w_stateNxt    = e_issue;
                  end else begin
                     w_stateNxt = e_idle;
                  end
               end else if (start_discovery_i) begin
                  w_pcNxt = pc_i;
               end
            end else if (r_tmoCnt == TW'(timeout_p - 1)) begin
               w_stateNxt = e_idle;
            end else begin
               w_tmoNxt = r_tmoCnt + TW'(1);
            end
         end
         e_issue: begin
            // A stalled request holds address, k and state untouched.
            if (!(r_pfV & ~pf_ready_i)) begin
               w_lastLineNxt = w_lastEval;
               if (w_kEval == KW'(pf_degree_p) || w_pageCross) begin
                  w_pfVNxt   = 1'b0;
                  w_stateNxt = e_idle;
               end else if (w_sameLine) begin
                  w_pfVNxt = 1'b0;
                  w_kNxt   = w_kEval + KW'(1);
                  if (w_kEval == KW'(pf_degree_p - 1)) begin
                     w_stateNxt = e_idle;
                  end
               end else begin
                  w_pfVNxt     = 1'b1;
                  w_pfVaddrNxt = w_candAligned;
                  w_kNxt       = w_kEval;
               end
            end
         end
         default: begin
            w_pfVNxt   = 1'b0;
            w_stateNxt = e_idle;
         end
      endcase

      if (flush_i) begin
         w_stateNxt = e_idle;
         w_pfVNxt   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state    <= e_idle;
         r_pc       <= '0;
         r_tmoCnt   <= '0;
         r_base     <= '0;
         r_stride   <= '0;
         r_k        <= '0;
         r_lastLine <= '0;
         r_pfV      <= 1'b0;
         r_pfVaddr  <= '0;
      end else begin
         r_state    <= w_stateNxt;
         r_pc       <= w_pcNxt;
         r_tmoCnt   <= w_tmoNxt;
         r_base     <= w_baseNxt;
         r_stride   <= w_strideNxt;
         r_k        <= w_kNxt;
         r_lastLine <= w_lastLineNxt;
         r_pfV      <= w_pfVNxt;
         r_pfVaddr  <= w_pfVaddrNxt;
      end
   end

   assign pf_v_o     = r_pfV;
   assign pf_vaddr_o = r_pfVaddr;
   assign busy_o     = (r_state != e_idle);

endmodule
